// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Brief    : LoongArch instruction fetch. It owns the PC, addresses the
//            synchronous IM and delivers {pc, instr, exc} to decode.
//            Optional perf counters are enabled with `define IF_PERF_EN.
// Revision : 1.0  initial release
// ============================================================================
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr,
  input  logic        im_exp,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [1:0]  id_exc,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  typedef enum logic [1:0] {
    BOOT       = 2'd0,
    RUN        = 2'd1,
    WAIT_REDIR = 2'd2
  } state_t;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_ADEF = 2'b01;
  localparam logic [1:0] EXC_IMF  = 2'b10;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fv_q, fv_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [1:0]  id_exc_q, id_exc_d;

  logic        stall;
  logic        load;
  logic [1:0]  exc_new;

  always_comb begin
    stall = id_valid_q && !id_ready;
    load  = fv_q && !stall && !redirect_valid;

    // Misalignment is reported ahead of an out-of-range fetch.
    if (pc_q[1:0] != 2'b00) begin
      exc_new = EXC_ADEF;
    end else if (im_exp) begin
      exc_new = EXC_IMF;
    end else begin
      exc_new = EXC_NONE;
    end

    // Holding re-fetches pc_q, so the word is back on im_instr after a stall.
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (state_q == BOOT) begin
      pc_d = RESET_PC;
    end else if (stall || (state_q == WAIT_REDIR)) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_q + 32'd4;
    end

    state_d = state_q;
    if (redirect_valid) begin
      state_d = RUN;
    end else if (state_q == BOOT) begin
      state_d = RUN;
    end else if ((state_q == RUN) && load && (exc_new != EXC_NONE)) begin
      state_d = WAIT_REDIR;
    end

    fv_d = (state_d != WAIT_REDIR);

    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_exc_d   = id_exc_q;
    if (redirect_valid) begin
      id_valid_d = 1'b0;
    end else if (load) begin
      id_valid_d = 1'b1;
      id_pc_d    = pc_q;
      id_exc_d   = exc_new;
      id_instr_d = (exc_new == EXC_NONE) ? im_instr : 32'h0;
    end else if (id_valid_q && id_ready) begin
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      fv_q       <= 1'b0;
      id_valid_q <= 1'b0;
      id_pc_q    <= 32'h0;
      id_instr_q <= 32'h0;
      id_exc_q   <= EXC_NONE;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fv_q       <= fv_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_exc_q   <= id_exc_d;
    end
  end

  assign im_addr  = pc_d;
  assign id_valid = id_valid_q;
  assign id_pc    = id_pc_q;
  assign id_instr = id_instr_q;
  assign id_exc   = id_exc_q;

`ifdef IF_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {31'd0, (id_valid_q && id_ready)};
    stall_cnt_d = stall_cnt_q + {31'd0, stall};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_fetch_cnt = 32'h0;
  assign perf_stall_cnt = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Brief    : Self-checking bench for if_stage: directed vector table, boot and
//            reset sequences, then random traffic against a stream-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_if_stage;

`ifdef IF_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic        im_exp;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [1:0]  id_exc;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;

  int checks   = 0;
  int failures = 0;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .im_addr        (im_addr),
    .im_instr       (im_instr),
    .im_exp         (im_exp),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
    .id_exc         (id_exc),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  always #5 clk = ~clk;

  // 4 KB synchronous instruction memory: word k holds 0xA000_0000 + k.
  always @(posedge clk) begin
    im_instr <= 32'hA000_0000 + {22'd0, im_addr[11:2]};
    im_exp   <= (im_addr >= 32'h0000_1000);
  end

  function automatic logic [1:0] f_exc(input logic [31:0] a);
    if (a[1:0] != 2'b00) return 2'b01;
    if (a >= 32'h0000_1000) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] f_instr(input logic [31:0] a);
    if (f_exc(a) != 2'b00) return 32'h0;
    return 32'hA000_0000 + {22'd0, a[11:2]};
  endfunction

  // Stream-level reference: decode sees the address sequence next, next+4, ...
  // restarting at each redirect, stopping after any faulting instruction.
  logic        m_valid;
  logic [31:0] m_pc, m_instr, m_next, m_fc, m_sc;
  logic [1:0]  m_exc;
  logic        m_boot, m_dead;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_pc <= 32'h0; m_instr <= 32'h0; m_exc <= 2'b00;
      m_next  <= 32'h0; m_boot <= 1'b1; m_dead <= 1'b0;
      m_fc    <= 32'h0; m_sc <= 32'h0;
    end else begin
      if (m_valid && id_ready)  m_fc <= m_fc + 32'd1;
      if (m_valid && !id_ready) m_sc <= m_sc + 32'd1;
      if (redirect_valid) begin
        m_valid <= 1'b0;
        m_next  <= redirect_pc;
        m_boot  <= 1'b0;
        m_dead  <= 1'b0;
      end else if (m_boot) begin
        m_boot <= 1'b0;
      end else if (!m_dead && (!m_valid || id_ready)) begin
        m_valid <= 1'b1;
        m_pc    <= m_next;
        m_instr <= f_instr(m_next);
        m_exc   <= f_exc(m_next);
        m_next  <= m_next + 32'd4;
        if (f_exc(m_next) != 2'b00) m_dead <= 1'b1;
      end else if (m_valid && id_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ei;
    logic [1:0]  ee;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rdy, input logic redir, input logic [31:0] rpc,
                     input logic ev, input logic [31:0] epc, input logic [31:0] ei,
                     input logic [1:0] ee);
    vec_t v;
    v.rdy = rdy; v.redir = redir; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.ei = ei; v.ee = ee;
    vq.push_back(v);
  endtask

  initial begin
    rst_n = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;

    add(1, 0, 0,       0, 0,       0,            0);  // E0: boot bubble
    add(1, 0, 0,       1, 32'h0,   32'hA0000000, 0);
    add(1, 0, 0,       1, 32'h4,   32'hA0000001, 0);
    add(1, 0, 0,       1, 32'h8,   32'hA0000002, 0);
    add(0, 0, 0,       1, 32'h8,   32'hA0000002, 0);
    add(0, 0, 0,       1, 32'h8,   32'hA0000002, 0);
    add(0, 0, 0,       1, 32'h8,   32'hA0000002, 0);
    add(1, 0, 0,       1, 32'hC,   32'hA0000003, 0);
    add(1, 0, 0,       1, 32'h10,  32'hA0000004, 0);
    add(0, 1, 32'h40,  0, 0,       0,            0);  // redirect beats stall
    add(0, 0, 0,       1, 32'h40,  32'hA0000010, 0);
    add(1, 0, 0,       1, 32'h44,  32'hA0000011, 0);
    add(1, 1, 32'h1000,0, 0,       0,            0);
    add(1, 0, 0,       1, 32'h1000,32'h0,        2);  // IMF
    for (int k = 0; k < 5; k++) add(1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 32'h10,  0, 0,       0,            0);
    add(1, 0, 0,       1, 32'h10,  32'hA0000004, 0);
    add(1, 1, 32'h1002,0, 0,       0,            0);
    add(1, 0, 0,       1, 32'h1002,32'h0,        1);  // ADEF wins over IMF
    add(1, 1, 32'h20,  0, 0,       0,            0);
    add(1, 0, 0,       1, 32'h20,  32'hA0000008, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_exc", {30'd0, id_exc}, 32'd0);
    chk("rst_im_addr", im_addr, 32'h0);
    chk("rst_fetch_cnt", perf_fetch_cnt, 32'h0);
    chk("rst_stall_cnt", perf_stall_cnt, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      id_ready = vq[i].rdy; redirect_valid = vq[i].redir; redirect_pc = vq[i].rpc;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), {31'd0, id_valid}, {31'd0, vq[i].ev});
      if (vq[i].ev) begin
        chk($sformatf("vec%0d_pc", i), id_pc, vq[i].epc);
        chk($sformatf("vec%0d_instr", i), id_instr, vq[i].ei);
        chk($sformatf("vec%0d_exc", i), {30'd0, id_exc}, {30'd0, vq[i].ee});
      end
      if (i == 6) begin
        chk("stall_cnt_after_3", perf_stall_cnt, PERF ? 32'd3 : 32'd0);
        chk("fetch_cnt_after_3", perf_fetch_cnt, PERF ? 32'd2 : 32'd0);
      end
    end

    // Asynchronous reset mid-stream while pc 0x20 is on the output.
    redirect_valid = 1'b0; id_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, id_valid}, 32'd0);
    chk("async_rst_fetch_cnt", perf_fetch_cnt, 32'h0);
    chk("async_rst_stall_cnt", perf_stall_cnt, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("restart_bubble", {31'd0, id_valid}, 32'd0);
    chk("restart_im_addr", im_addr, 32'h4);
    @(posedge clk); #1;
    chk("restart_valid", {31'd0, id_valid}, 32'd1);
    chk("restart_pc", id_pc, 32'h0);
    chk("restart_instr", id_instr, 32'hA0000000);

    // Redirect during BOOT replaces RESET_PC.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    chk("boot_redir_bubble", {31'd0, id_valid}, 32'd0);
    @(posedge clk); #1;
    chk("boot_redir_valid", {31'd0, id_valid}, 32'd1);
    chk("boot_redir_pc", id_pc, 32'h80);
    chk("boot_redir_instr", id_instr, 32'hA0000020);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] r;
      id_ready       = ($urandom % 4) != 0;
      redirect_valid = m_dead ? (($urandom % 4) == 0) : (($urandom % 24) == 0);
      r = $urandom;
      case ($urandom % 4)
        0: redirect_pc = (r % 1024) * 4;
        1: redirect_pc = 32'hFF0 + (r % 4) * 4;
        2: redirect_pc = (r % 1024) * 4 + 1 + (r % 3);
        default: redirect_pc = (r % 8 == 0) ? r : 32'h1000 + (r % 64) * 4;
      endcase
      rst_n = (i != 1500);
      @(posedge clk);
      #1;
      chk("rnd_valid", {31'd0, id_valid}, {31'd0, m_valid});
      if (m_valid) begin
        chk("rnd_pc", id_pc, m_pc);
        chk("rnd_instr", id_instr, m_instr);
        chk("rnd_exc", {30'd0, id_exc}, {30'd0, m_exc});
      end
      chk("rnd_fetch_cnt", perf_fetch_cnt, PERF ? m_fc : 32'h0);
      chk("rnd_stall_cnt", perf_stall_cnt, PERF ? m_sc : 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage for the five-stage LoongArch pipeline. It owns the PC, generates the next-fetch address for the synchronous 4 KB instruction memory, and aligns each returned instruction word with its PC. It also tags fetch exceptions and delivers {pc, instr, exc} to decode through a valid/ready pipeline register. Branch/exception redirects from downstream flush it.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk`  in  1  pipeline clock; all state updates on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `im_addr`  out  32  byte address presented to instruction memory (combinational, = npc).
- `im_instr`  in  32  instruction word returned one cycle after `im_addr`.
- `im_exp`  in  1  out-of-range flag returned with `im_instr`.
- `redirect_valid`  in  1  flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  redirect target.
- `id_ready`  in  1  decode accepts the output this cycle.
- `id_valid`  out  1  output register holds a valid fetched instruction.
- `id_pc`  out  32  PC of `id_instr`.
- `id_instr`  out  32  instruction word; 32'h0 when `id_exc`≠0.
- `id_exc`  out  2  00 none, 01 ADEF (misaligned PC), 10 IMF (`im_exp`).
- `perf_fetch_cnt`  out  32  delivered-instruction counter (see Configuration).
- `perf_stall_cnt`  out  32  back-pressure cycle counter (see Configuration).

## Operation
- State register: BOOT, RUN, WAIT_REDIR.
- `pc_q` holds the address whose word is on `im_instr` this cycle. `fv_q` marks that word valid.
- npc priority:
  1. `redirect_valid` → `redirect_pc`.
  2. BOOT → `RESET_PC`.
  3. hold (`id_valid && !id_ready`, or WAIT_REDIR) → `pc_q`. Re-fetch is used instead of a skid buffer.
  4. otherwise → `pc_q + 4` (mod 2^32, wraps silently).
- `im_addr = npc` always. `pc_q <= npc` every cycle.
- `fv_q <= 1` on redirect, and in BOOT, and in RUN. `fv_q <= 0` when entering or staying in WAIT_REDIR.
- Output load, when `fv_q && !(id_valid && !id_ready) && !redirect_valid`:
  - `id_valid <= 1`, `id_pc <= pc_q`.
  - Exception code: `pc_q[1:0]≠0` → 01 (takes precedence over IMF). Else `im_exp` → 10. Else 00 with `id_instr <= im_instr`.
- Output clear: `id_valid <= 0` on `redirect_valid`, or on handshake (`id_valid && id_ready`) with no new load.
- Transitions:
  - BOOT → RUN after one cycle.
  - RUN → WAIT_REDIR when a load carries `id_exc≠0`. No further loads occur until a redirect.
  - Any state → RUN on `redirect_valid`.
- Simultaneous events:
  - Redirect beats stall: the output is flushed even if `id_ready=0`.
  - Redirect in BOOT is honoured: the target replaces `RESET_PC`.
- Reset values: state=BOOT, `pc_q`=`RESET_PC`, `fv_q`=0, `id_valid`=0, `id_pc`=0, `id_instr`=0, `id_exc`=0, perf counters=0.
- Reset asserted mid-operation: all of the above apply immediately (asynchronous). The in-flight IM word is discarded.

## Timing
- Reset released before edge E0 (BOOT): `im_addr`=`RESET_PC`. After E1: `id_valid`=1 with `RESET_PC`.
- Throughput: 1 instruction/cycle with `id_ready` held high.
- Redirect sampled at edge E: target instruction appears on `id_*` after E+1. Redirect-to-valid latency is 2 cycles; exactly one bubble cycle.
- Stall: `id_*` stable while `id_valid && !id_ready`. The next instruction appears the cycle after the handshake, with no bubble, because re-fetch of `pc_q` is in flight.

## Configuration
- `IF_PERF_EN` defined:
  - `perf_fetch_cnt` increments on each `id_valid && id_ready`.
  - `perf_stall_cnt` increments on each `id_valid && !id_ready` cycle.
  - Both are 32-bit, wrap at 2^32, and are cleared by reset only.
- `IF_PERF_EN` undefined: both ports are tied to 32'h0 and no counter flops exist. The port list is unchanged.

## Test plan
- Reset release, `RESET_PC`=0, `id_ready`=1, memory word k = 0xA000_0000+k → outputs (0,0xA0000000), (4,0xA0000001), (8,0xA0000002) on consecutive cycles starting 2 cycles after reset release.
- `id_ready`=0 for 3 cycles while holding pc=8 → `id_*` frozen at pc 8 and `perf_stall_cnt`=3 (with `IF_PERF_EN`). After `id_ready` rises: pc 8 then pc 12 back-to-back, no duplicate and no gap.
- `redirect_valid` with `redirect_pc`=0x40 and `id_ready`=0 in the same cycle → `id_valid`=0 next cycle, then pc 0x40 valid on the following cycle.
- Redirect to 0x0000_1000 (beyond 4 KB) → `id_valid`=1, `id_exc`=10, `id_instr`=0, state WAIT_REDIR, no further valids for 5 cycles. Redirect to 0x10 → pc 0x10 delivered with `id_exc`=00.
- Redirect to 0x0000_1002 → `id_exc`=01 (ADEF wins over IMF).
- Assert `rst_n` low mid-stream at pc 0x20 → `id_valid` drops asynchronously. After release, fetch restarts at `RESET_PC` and the perf counters read 0.
